mitchell_antilog_pipe: RTL
==========================

// Module: mitchell_antilog_pipe
// PURPOSE
//  Parametrised, pipelined Mitchell antilog decoder: successor of the combinational
//  11-bit -> 16-bit decoder. Takes a log-domain word {k, f}, returns (1.f) * 2^k as an
//  integer. Adds valid/ready flow control, optional rounding, saturation with a sticky
//  counter, and a zero-operand bypass. Sits after the log-domain adder of the ETM datapath.
// PARAMETERS
//  K_W    4   characteristic (integer exponent) width; k = in_log[K_W+F_W-1:F_W]
//  F_W    7   fraction width; f = in_log[F_W-1:0]
//  OUT_W  16  result width
//  CNT_W  16  saturation event counter width
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous active-low reset
//  in_valid   in   1          input word valid
//  in_ready   out  1          decoder can accept input this cycle
//  in_log     in   K_W+F_W    log-domain operand {k, f}
//  in_zero    in   1          operand is exact zero (forces result 0)
//  round_en   in   1          1: round-half-up dropped bits; 0: truncate; sampled with input
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  OUT_W      antilog result
//  out_sat    out  1          result was clamped to all-ones (qualified by out_valid)
//  sat_cnt    out  CNT_W      number of saturated results delivered; sticks at all-ones
//  clr_cnt    in   1          synchronous clear of sat_cnt
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): s1_valid=s2_valid=0, out_valid=0, out_data=0,
//    out_sat=0, sat_cnt=0. Reset mid-operation discards all in-flight words.
//  - Two register stages, latency exactly 2 cycles when out_ready stays high;
//    throughput 1 word/cycle.
//  - Stage 1 (capture on in_valid&in_ready): k, m={1'b1,f} (F_W+1 bits), in_zero, round_en.
//  - Stage 2 result, computed from stage-1 registers:
//      k >= F_W: r = m << (k-F_W) (full-width, no bits dropped).
//      k <  F_W: r = m >> (F_W-k); if round_en, r += bit (F_W-k-1) of m (round half up).
//      r >= 2^OUT_W (shift or round carry): out_data = {OUT_W{1'b1}}, out_sat=1.
//      in_zero=1: out_data=0, out_sat=0 regardless of k, f.
//    Internal width for r: OUT_W+F_W+2 bits minimum, so no silent overflow.
//  - Handshake: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2;
//    in_ready = adv1 (combinational from out_ready). Stage 2 loads when s1_valid&adv2;
//    s2 clears when out_ready and s1 empty. out_data/out_sat held stable while
//    out_valid&!out_ready. No word dropped or duplicated under any stall pattern.
//  - sat_cnt increments on each out_valid&out_ready&out_sat; saturates at all-ones.
//    clr_cnt same cycle as an increment: clear wins (sat_cnt=0).
//  - Default params reproduce the legacy decoder exactly with round_en=0, in_zero=0
//    (no saturation reachable: max 255<<8 = 65280).
// TESTING
//  1. Sweep in_log 1..2047, round_en=0, out_ready=1 -> out_data matches legacy antilog
//     table, each result 2 cycles after input; e.g. 11'd1 -> 1, {4'd15,7'd0} -> 32768,
//     {4'd15,7'h7F} -> 65280.
//  2. Rounding: in_log={4'd1,7'h7F} -> 3 (round_en=0), 4 (round_en=1);
//     {4'd6,7'h7F} round_en=1 -> 128, out_sat=0.
//  3. Zero bypass: in_zero=1, in_log={4'd15,7'h7F} -> out_data=0, out_sat=0.
//  4. Saturation, OUT_W=12 instance: {4'd15,7'd0} -> 12'hFFF, out_sat=1, sat_cnt 0->1;
//     three more -> 4; clr_cnt asserted with a saturated handshake -> sat_cnt=0.
//  5. Backpressure: stream 20 words, out_ready random 50% -> results in order, none lost,
//     in_ready=0 exactly when both stages full and out_ready=0; out_data stable in stalls.
//  6. Reset mid-stream with both stages full -> next cycle out_valid=0, sat_cnt=0,
//     in_ready=1; next accepted word emerges after 2 cycles with correct value.

Source files
------------

// File: rtl/mitchell_antilog_pipe.sv
// Two-stage pipelined Mitchell antilog decoder: {k, f} -> (1.f) * 2^k as an integer,
// with valid/ready flow control, optional round-half-up, saturation counting and zero bypass.
module mitchell_antilog_pipe #(
    parameter int K_W   = 4,
    parameter int F_W   = 7,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K_W+F_W-1:0]   in_log,
    input  logic                 in_zero,
    input  logic                 round_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_sat,
    output logic [CNT_W-1:0]     sat_cnt,
    input  logic                 clr_cnt
);

    localparam int RW = OUT_W + F_W + 2;

    logic             s1_valid;
    logic [K_W-1:0]   s1_k;
    logic [F_W:0]     s1_m;
    logic             s1_zero;
    logic             s1_round;
    logic             s2_valid;
    logic             adv1;
    logic             adv2;

    // Handshake: a stage advances when it is empty or the stage after it is moving.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    logic [31:0]      k32;
    logic [RW-1:0]    m_ext;
    logic [RW-1:0]    r;
    logic [RW-1:0]    rb;
    logic             over;
    logic [OUT_W-1:0] nxt_data;
    logic             nxt_sat;

    always_comb begin
        k32   = 32'(s1_k);
        m_ext = RW'(s1_m);
        r     = '0;
        rb    = '0;
        over  = 1'b0;
        if (k32 >= 32'(F_W)) begin
            // With the leading one at bit F_W, k >= OUT_W always lands at or above 2^OUT_W.
            if (k32 >= 32'(OUT_W))
                over = 1'b1;
            else
                r = m_ext << (k32 - 32'(F_W));
        end else begin
            r  = m_ext >> (32'(F_W) - k32);
            rb = m_ext >> (32'(F_W) - k32 - 32'd1);
            if (s1_round)
                r = r + RW'(rb[0]);
        end
        if ((r >> OUT_W) != '0)
            over = 1'b1;
        nxt_sat  = !s1_zero && over;
        if (s1_zero)
            nxt_data = '0;
        else if (over)
            nxt_data = '1;
        else
            nxt_data = r[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_k     <= '0;
            s1_m     <= '0;
            s1_zero  <= 1'b0;
            s1_round <= 1'b0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            sat_cnt  <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_k     <= in_log[K_W+F_W-1:F_W];
                    s1_m     <= {1'b1, in_log[F_W-1:0]};
                    s1_zero  <= in_zero;
                    s1_round <= round_en;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= nxt_data;
                    out_sat  <= nxt_sat;
                end
            end
            // Clear has priority over a same-cycle saturated delivery.
            if (clr_cnt)
                sat_cnt <= '0;
            else if (s2_valid && out_ready && out_sat && (sat_cnt != '1))
                sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule
